// File: rtl/ps2_kb_event_fifo.sv
// PS/2 keyboard receiver with make/break/E0 decode, modifier tracking and an FWFT event FIFO.
// Optional KB_REPEAT_FILTER_EN suppresses typematic repeats of the held key.
module ps2_kb_event_fifo #(
    parameter int FIFO_AW     = 4,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ps2c,
    input  logic               ps2d,
    output logic [7:0]         evt_code,
    output logic               evt_ext,
    output logic               evt_break,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               upper_case,
    output logic               frame_err,
    output logic               overflow,
    input  logic               ovf_clr
);

    localparam int DEPTH = 2**FIFO_AW;
    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    logic          r_c_s1, r_c_s2, r_d_s1, r_d_s2;
    logic          r_c_flt;
    logic [FW-1:0] r_flt_cnt;
    logic          w_flip, w_fall;

    state_t        r_state, w_state_nx;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par_ok;
    logic [TW-1:0] r_to_cnt;
    logic          w_tmo, w_stop, w_good, w_ferr;
    logic          r_byte_vld;
    logic [7:0]    r_byte;
    logic          r_frame_err;

    logic          r_ext_pend, r_brk_pend;
    logic          r_lshift, r_rshift, r_caps;
    logic          w_evt_req, w_suppress, w_push_req;

    logic [9:0]         r_mem [DEPTH];
    logic [FIFO_AW:0]   r_wptr, r_rptr;
    logic [FIFO_AW:0]   w_count;
    logic               w_empty, w_full, w_pop, w_push, w_drop;
    logic [9:0]         w_head;
    logic               r_ovf;

    // Synchronisers idle high so reset does not look like a falling edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c_s1    <= 1'b1;
            r_c_s2    <= 1'b1;
            r_d_s1    <= 1'b1;
            r_d_s2    <= 1'b1;
            r_c_flt   <= 1'b1;
            r_flt_cnt <= '0;
        end else begin
            r_c_s1 <= ps2c;
            r_c_s2 <= r_c_s1;
            r_d_s1 <= ps2d;
            r_d_s2 <= r_d_s1;
            if (r_c_s2 == r_c_flt) begin
                r_flt_cnt <= '0;
            end else if (w_flip) begin
                r_c_flt   <= ~r_c_flt;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

    assign w_flip = (r_c_s2 != r_c_flt) && (r_flt_cnt == FW'(FILTER_LEN - 1));
    assign w_fall = w_flip && r_c_flt;

    assign w_tmo  = (r_state != S_IDLE) && !w_fall &&
                    (r_to_cnt == TW'(TIMEOUT_CYC - 1));
    assign w_stop = (r_state == S_STOP) && w_fall;
    assign w_good = w_stop && r_d_s2 && r_par_ok;
    assign w_ferr = (w_stop && !w_good) || w_tmo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: if (w_fall && !r_d_s2)            w_state_nx = S_DATA;
            S_DATA: if (w_fall && r_bit_cnt == 3'd7) w_state_nx = S_PAR;
            S_PAR:  if (w_fall)                       w_state_nx = S_STOP;
            S_STOP: if (w_fall)                       w_state_nx = S_IDLE;
            default:                                  w_state_nx = S_IDLE;
        endcase
        if (w_tmo) w_state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_ok    <= 1'b0;
            r_to_cnt    <= '0;
            r_byte_vld  <= 1'b0;
            r_byte      <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_vld  <= w_good;
            r_frame_err <= w_ferr;
            if (w_good) r_byte <= r_shift;
            if (r_state == S_IDLE || w_fall) r_to_cnt <= '0;
            else                              r_to_cnt <= r_to_cnt + 1'b1;
            if (r_state == S_IDLE) begin
                r_bit_cnt <= '0;
            end else if (r_state == S_DATA && w_fall) begin
                r_shift   <= {r_d_s2, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (r_state == S_PAR && w_fall) begin
                r_par_ok  <= ^{r_shift, r_d_s2};
            end
        end
    end

    assign w_evt_req = r_byte_vld && (r_byte != 8'hE0) && (r_byte != 8'hF0);

`ifdef KB_REPEAT_FILTER_EN
    logic       r_held_vld;
    logic [7:0] r_held_code;
    logic       r_held_ext;
    logic       w_is_mod, w_held_hit;

    assign w_is_mod   = !r_ext_pend &&
                        (r_byte == 8'h12 || r_byte == 8'h59 || r_byte == 8'h58);
    assign w_held_hit = r_held_vld && (r_held_code == r_byte) &&
                        (r_held_ext == r_ext_pend);
    assign w_suppress = w_evt_req && !r_brk_pend && w_held_hit && !w_is_mod;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_held_vld  <= 1'b0;
            r_held_code <= '0;
            r_held_ext  <= 1'b0;
        end else if (w_push_req && !r_brk_pend) begin
            r_held_vld  <= 1'b1;
            r_held_code <= r_byte;
            r_held_ext  <= r_ext_pend;
        end else if (w_evt_req && r_brk_pend && w_held_hit) begin
            r_held_vld  <= 1'b0;
        end
    end
`else
    assign w_suppress = 1'b0;
`endif

    assign w_push_req = w_evt_req && !w_suppress;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (w_ferr) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (r_byte_vld) begin
            if (r_byte == 8'hE0) begin
                r_ext_pend <= 1'b1;
            end else if (r_byte == 8'hF0) begin
                r_brk_pend <= 1'b1;
            end else begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end
        end
    end

    // E0-prefixed 12/59 are fake shifts from the extended keys, not modifiers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lshift <= 1'b0;
            r_rshift <= 1'b0;
            r_caps   <= 1'b0;
        end else if (w_push_req && !r_ext_pend) begin
            if (r_byte == 8'h12) r_lshift <= !r_brk_pend;
            if (r_byte == 8'h59) r_rshift <= !r_brk_pend;
            if (r_byte == 8'h58 && !r_brk_pend) r_caps <= ~r_caps;
        end
    end

    assign w_count = r_wptr - r_rptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == (FIFO_AW + 1)'(DEPTH));
    assign w_pop   = !w_empty && evt_ready;
    assign w_push  = w_push_req && (!w_full || w_pop);
    assign w_drop  = w_push_req && !w_push;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[FIFO_AW-1:0]] <= {r_brk_pend, r_ext_pend, r_byte};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_drop)       r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

    assign w_head     = r_mem[r_rptr[FIFO_AW-1:0]];
    assign evt_valid  = !w_empty;
    assign evt_code   = evt_valid ? w_head[7:0] : 8'h00;
    assign evt_ext    = evt_valid & w_head[8];
    assign evt_break  = evt_valid & w_head[9];
    assign fifo_count = w_count;
    assign upper_case = (r_lshift | r_rshift) ^ r_caps;
    assign frame_err  = r_frame_err;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_ps2_kb_event_fifo.sv
// Directed bench for ps2_kb_event_fifo: frames, prefixes, modifiers,
// errors, timeout, overflow and repeat behaviour (honours KB_REPEAT_FILTER_EN).
module tb_ps2_kb_event_fifo;

    localparam int AW  = 2;
    localparam int FL  = 2;
    localparam int TMO = 300;

    logic          clk = 1'b0;
    logic          reset, ps2c, ps2d, evt_ready, ovf_clr;
    logic [7:0]    evt_code;
    logic          evt_ext, evt_break, evt_valid;
    logic [AW:0]   fifo_count;
    logic          upper_case, frame_err, overflow;

    int n_chk = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int fe0;

    ps2_kb_event_fifo #(
        .FIFO_AW(AW), .FILTER_LEN(FL), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d),
        .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .fifo_count(fifo_count), .upper_case(upper_case),
        .frame_err(frame_err), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0 plain, 1 latency check, 2 pop at push cycle, 3 ovf_clr at push cycle
    task automatic send(input logic [7:0] b, input bit bad_par,
                        input bit bad_stop, input int nbits, input int mode);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = f[i];
            repeat (5) @(posedge clk);
            #1 ps2c = 1'b0;
            if (i == 10 && mode != 0) begin
                repeat (4) @(posedge clk);
                #1;
                if (mode == 1) chk("lat_lo", evt_valid, 1'b0);
                if (mode == 2) evt_ready = 1'b1;
                if (mode == 3) ovf_clr = 1'b1;
                @(posedge clk);
                #1;
                if (mode == 1) chk("lat_hi", evt_valid, 1'b1);
                evt_ready = 1'b0;
                ovf_clr   = 1'b0;
                repeat (5) @(posedge clk);
            end else begin
                repeat (10) @(posedge clk);
            end
            #1 ps2c = 1'b1;
        end
        ps2d = 1'b1;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic pop(input string tag, input logic [7:0] c,
                       input logic e, input logic k);
        chk({tag, "_v"}, evt_valid, 1'b1);
        chk({tag, "_c"}, evt_code, c);
        chk({tag, "_e"}, evt_ext, e);
        chk({tag, "_b"}, evt_break, k);
        evt_ready = 1'b1;
        @(posedge clk);
        #1 evt_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; ps2c = 1'b1; ps2d = 1'b1;
        evt_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_count", fifo_count, 0);
        chk("rst_code", evt_code, 8'h00);
        chk("rst_upper", upper_case, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        send(8'h1C, 0, 0, 11, 1);
        pop("a", 8'h1C, 0, 0);
        chk("a_empty", evt_valid, 1'b0);

        send(8'hE0, 0, 0, 11, 0);
        send(8'hF0, 0, 0, 11, 0);
        chk("pref_none", fifo_count, 0);
        send(8'h75, 0, 0, 11, 0);
        chk("up_cnt", fifo_count, 1);
        pop("up", 8'h75, 1, 1);

        send(8'h12, 0, 0, 11, 0);
        chk("lsh_up", upper_case, 1'b1);
        pop("lsh", 8'h12, 0, 0);
        send(8'h1C, 0, 0, 11, 0);
        pop("A", 8'h1C, 0, 0);
        send(8'hF0, 0, 0, 11, 0);
        send(8'h12, 0, 0, 11, 0);
        chk("lsh_rel", upper_case, 1'b0);
        pop("lshr", 8'h12, 0, 1);
        send(8'h58, 0, 0, 11, 0);
        chk("caps_on", upper_case, 1'b1);
        pop("caps1", 8'h58, 0, 0);
        send(8'h58, 0, 0, 11, 0);
        chk("caps_off", upper_case, 1'b0);
        pop("caps2", 8'h58, 0, 0);
        send(8'hF0, 0, 0, 11, 0);
        send(8'h58, 0, 0, 11, 0);
        chk("caps_brk", upper_case, 1'b0);
        pop("capsr", 8'h58, 0, 1);

        fe0 = fe_cnt;
        send(8'h1C, 1, 0, 11, 0);
        chk("par_fe", fe_cnt, fe0 + 1);
        chk("par_noevt", evt_valid, 1'b0);
        send(8'h1C, 0, 1, 11, 0);
        chk("stop_fe", fe_cnt, fe0 + 2);
        chk("stop_noevt", evt_valid, 1'b0);

        fe0 = fe_cnt;
        send(8'h1C, 0, 0, 5, 0);
        repeat (100) @(posedge clk);
        #1 chk("tmo_early", fe_cnt, fe0);
        repeat (250) @(posedge clk);
        #1 chk("tmo_fe", fe_cnt, fe0 + 1);
        send(8'h1C, 0, 0, 11, 0);
        pop("tmo_ok", 8'h1C, 0, 0);

        send(8'hE0, 0, 0, 11, 0);
        send(8'h33, 1, 0, 11, 0);
        send(8'h1B, 0, 0, 11, 0);
        pop("fe_clrpend", 8'h1B, 0, 0);

        send(8'h1C, 0, 0, 11, 0);
        send(8'h32, 0, 0, 11, 0);
        send(8'h21, 0, 0, 11, 0);
        send(8'h23, 0, 0, 11, 0);
        chk("full_noovf", overflow, 1'b0);
        send(8'h24, 0, 0, 11, 0);
        chk("ovf_cnt", fifo_count, 4);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_head", evt_code, 8'h1C);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 1'b0);
        send(8'h2B, 0, 0, 11, 2);
        chk("pp_cnt", fifo_count, 4);
        chk("pp_noovf", overflow, 1'b0);
        chk("pp_head", evt_code, 8'h32);
        send(8'h2D, 0, 0, 11, 3);
        chk("setwins", overflow, 1'b1);
        chk("setwins_cnt", fifo_count, 4);
        pop("d0", 8'h32, 0, 0);
        pop("d1", 8'h21, 0, 0);
        pop("d2", 8'h23, 0, 0);
        pop("d3", 8'h2B, 0, 0);
        chk("drain", fifo_count, 0);

        fe0 = fe_cnt;
        send(8'hE0, 0, 0, 11, 0);
        send(8'h1C, 0, 0, 5, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_cnt", fifo_count, 0);
        chk("mid_ovf", overflow, 1'b0);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(8'h1C, 0, 0, 11, 0);
        chk("mid_nofe", fe_cnt, fe0);
        pop("mid_ok", 8'h1C, 0, 0);

        send(8'h1D, 0, 0, 11, 0);
        send(8'h1D, 0, 0, 11, 0);
        send(8'h1D, 0, 0, 11, 0);
        send(8'hF0, 0, 0, 11, 0);
        send(8'h1D, 0, 0, 11, 0);
`ifdef KB_REPEAT_FILTER_EN
        chk("rep_cnt", fifo_count, 2);
        pop("rep0", 8'h1D, 0, 0);
        pop("rep1", 8'h1D, 0, 1);
`else
        chk("rep_cnt", fifo_count, 4);
        pop("rep0", 8'h1D, 0, 0);
        pop("rep1", 8'h1D, 0, 0);
        pop("rep2", 8'h1D, 0, 0);
        pop("rep3", 8'h1D, 0, 1);
`endif
        chk("rep_empty", evt_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
